// File: rtl/proc_seq_pkg.sv
// Shared definitions for the processor stage sequencer and its decoders.
// Holds state encodings and the opcode/funct constants the sequencer cares about.
package proc_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXE    = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_PUSH  = 6'h1b;
    localparam logic [5:0] OP_POP   = 6'h1c;
    localparam logic [5:0] OP_X1D   = 6'h1d;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR    = 6'h08;

endpackage

// File: rtl/proc_op_classifier.sv
// Combinational opcode classifier shared by the sequencer and control decoder.
// In: opcode_i, funct_i. Out: is_mem_read_o, is_mem_write_o, is_rf_write_o.
module proc_op_classifier
    import proc_seq_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output logic       is_mem_read_o,
    output logic       is_mem_write_o,
    output logic       is_rf_write_o
);

    always_comb begin
        is_mem_read_o  = (opcode_i == OP_LW) || (opcode_i == OP_POP);
        is_mem_write_o = (opcode_i == OP_SW) || (opcode_i == OP_PUSH);
        is_rf_write_o  = 1'b0;
        unique case (opcode_i)
            OP_RTYPE: is_rf_write_o = (funct_i != FN_JR);
            OP_ADDI, OP_X1D, OP_ANDI, OP_ORI, OP_LUI,
            OP_SLTI, OP_LW, OP_JAL, OP_POP:
                is_rf_write_o = 1'b1;
            default:  is_rf_write_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/proc_stage_sequencer.sv
// Multi-cycle FETCH/DECODE/EXE/MEM/WB sequencer with memory wait timeout.
// In: CLK, RST, RUN, INSTRUCTION, MEM_READY. Out: STATE, IR, strobes, BUSY,
// TIMEOUT_ERR, INST_COUNT.
module proc_stage_sequencer
    import proc_seq_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_WAIT_MAX = 15,
    parameter int SKIP_MEM     = 1,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RUN,
    input  logic [DATA_WIDTH-1:0] INSTRUCTION,
    input  logic                  MEM_READY,
    output logic [2:0]            STATE,
    output logic [DATA_WIDTH-1:0] IR,
    output logic                  READ,
    output logic                  WRITE,
    output logic                  IR_LOAD,
    output logic                  RF_READ,
    output logic                  RF_WRITE,
    output logic                  PC_LOAD,
    output logic                  BUSY,
    output logic                  TIMEOUT_ERR,
    output logic [CNT_WIDTH-1:0]  INST_COUNT
);

    localparam int WAIT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MEM_WAIT_MAX);
    localparam bit TMO_EN = (MEM_WAIT_MAX > 0);
    localparam bit SKIP_EN = (SKIP_MEM != 0);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic                  terr_q, terr_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic rd_q, rd_d;
    logic wr_q, wr_d;
    logic rfr_q, rfr_d;
    logic rfw_q, rfw_d;
    logic pcl_q, pcl_d;
    logic busy_q, busy_d;

    logic op_rd, op_wr, op_rfw, op_mem, tmo_hit;

    // IR only changes on FETCH->DECODE, so classifying ir_q is valid
    // for every transition into EXE, MEM and WB.
    proc_op_classifier u_cls (
        .opcode_i       (ir_q[DATA_WIDTH-1:DATA_WIDTH-6]),
        .funct_i        (ir_q[5:0]),
        .is_mem_read_o  (op_rd),
        .is_mem_write_o (op_wr),
        .is_rf_write_o  (op_rfw)
    );

    assign op_mem  = op_rd | op_wr;
    assign tmo_hit = TMO_EN && (wait_q == WAIT_LIM);

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        wait_d  = wait_q;
        terr_d  = terr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (RUN) begin
                    state_d = S_FETCH;
                    wait_d  = '0;
                end
            end
            S_FETCH: begin
                if (MEM_READY) begin
                    ir_d    = INSTRUCTION;
                    state_d = S_DECODE;
                end else if (tmo_hit) begin
                    state_d = S_HALT;
                    terr_d  = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DECODE: state_d = S_EXE;
            S_EXE: begin
                if (op_mem || !SKIP_EN) begin
                    state_d = S_MEM;
                    wait_d  = '0;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                // Non-memory ops pass through MEM in one cycle.
                if (!op_mem || MEM_READY) begin
                    state_d = S_WB;
                end else if (tmo_hit) begin
                    state_d = S_HALT;
                    terr_d  = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WB: begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
                if (RUN) begin
                    state_d = S_FETCH;
                    wait_d  = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    // Strobes are registered from the next state so they are glitch-free
    // and stable for the whole time the state is held.
    always_comb begin
        rd_d   = (state_d == S_FETCH) || ((state_d == S_MEM) && op_rd);
        wr_d   = (state_d == S_MEM) && op_wr;
        rfr_d  = (state_d == S_DECODE);
        rfw_d  = (state_d == S_WB) && op_rfw;
        pcl_d  = (state_d == S_WB);
        busy_d = (state_d != S_IDLE) && (state_d != S_HALT);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            wait_q  <= '0;
            terr_q  <= 1'b0;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rfr_q   <= 1'b0;
            rfw_q   <= 1'b0;
            pcl_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            wait_q  <= wait_d;
            terr_q  <= terr_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            rfr_q   <= rfr_d;
            rfw_q   <= rfw_d;
            pcl_q   <= pcl_d;
            busy_q  <= busy_d;
        end
    end

    assign STATE       = state_q;
    assign IR          = ir_q;
    assign READ        = rd_q;
    assign WRITE       = wr_q;
    assign IR_LOAD     = (state_q == S_FETCH) && MEM_READY;
    assign RF_READ     = rfr_q;
    assign RF_WRITE    = rfw_q;
    assign PC_LOAD     = pcl_q;
    assign BUSY        = busy_q;
    assign TIMEOUT_ERR = terr_q;
    assign INST_COUNT  = cnt_q;

endmodule

// File: tb/tb_proc_stage_sequencer.sv
// Bench for proc_stage_sequencer: two configurations driven in lockstep
// and checked every cycle against a phase-level reference model.
module tb_proc_stage_sequencer;

    localparam logic [31:0] ADD = 32'h00221820;
    localparam logic [31:0] LW  = 32'h8C220004;
    localparam logic [31:0] SW  = 32'hAC220004;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        RUN = 1'b0;
    logic        MEM_READY = 1'b0;
    logic [31:0] INSTRUCTION = '0;

    always #5 CLK = ~CLK;

    logic [2:0]  st0, st1;
    logic [31:0] ir0, ir1;
    logic        rd0, wr0, irl0, rfr0, rfw0, pcl0, busy0, terr0;
    logic        rd1, wr1, irl1, rfr1, rfw1, pcl1, busy1, terr1;
    logic [15:0] cnt0;
    logic [3:0]  cnt1;

    proc_stage_sequencer u_dut0 (
        .CLK(CLK), .RST(RST), .RUN(RUN),
        .INSTRUCTION(INSTRUCTION), .MEM_READY(MEM_READY),
        .STATE(st0), .IR(ir0), .READ(rd0), .WRITE(wr0),
        .IR_LOAD(irl0), .RF_READ(rfr0), .RF_WRITE(rfw0),
        .PC_LOAD(pcl0), .BUSY(busy0), .TIMEOUT_ERR(terr0),
        .INST_COUNT(cnt0)
    );

    proc_stage_sequencer #(
        .DATA_WIDTH(32), .MEM_WAIT_MAX(0),
        .SKIP_MEM(0), .CNT_WIDTH(4)
    ) u_dut1 (
        .CLK(CLK), .RST(RST), .RUN(RUN),
        .INSTRUCTION(INSTRUCTION), .MEM_READY(MEM_READY),
        .STATE(st1), .IR(ir1), .READ(rd1), .WRITE(wr1),
        .IR_LOAD(irl1), .RF_READ(rfr1), .RF_WRITE(rfw1),
        .PC_LOAD(pcl1), .BUSY(busy1), .TIMEOUT_ERR(terr1),
        .INST_COUNT(cnt1)
    );

    typedef struct packed {
        logic [2:0]  st;
        logic [31:0] ir;
        logic        rd, wr, irl, rfr, rfw, pcl, busy, terr;
        logic [15:0] cnt;
    } obs_t;

    obs_t o0, o1;
    assign o0 = {st0, ir0, rd0, wr0, irl0, rfr0, rfw0, pcl0,
                 busy0, terr0, cnt0};
    assign o1 = {st1, ir1, rd1, wr1, irl1, rfr1, rfw1, pcl1,
                 busy1, terr1, 12'd0, cnt1};

    int checks = 0;
    int failures = 0;

    task automatic ck(input string nm, input logic [63:0] a,
                      input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h @%0t", nm, a, e, $time);
        end
    endtask

    // Reference model: phase numbers are the architectural STATE values.
    typedef struct {
        int          ph;
        logic [31:0] ir;
        int          wt;
        bit          terr;
        int          cnt;
    } mdl_t;

    mdl_t m[2];
    int   c_max[2]  = '{15, 0};
    bit   c_skip[2] = '{1'b1, 1'b0};
    int   c_cw[2]   = '{16, 4};
    bit   mon_en = 1'b0;

    function automatic bit is_rd(logic [31:0] ir);
        logic [5:0] op = ir[31:26];
        return op == 6'h23 || op == 6'h1c;
    endfunction

    function automatic bit is_wr(logic [31:0] ir);
        logic [5:0] op = ir[31:26];
        return op == 6'h2b || op == 6'h1b;
    endfunction

    function automatic bit rf_wr(logic [31:0] ir);
        logic [5:0] op = ir[31:26];
        logic [5:0] fn = ir[5:0];
        if (op == 6'h00) return fn != 6'h08;
        return op inside {6'h08, 6'h1d, 6'h0c, 6'h0d, 6'h0f,
                          6'h0a, 6'h23, 6'h03, 6'h1c};
    endfunction

    function automatic mdl_t nxt(mdl_t x, int k, bit rst, bit run,
                                 logic [31:0] ins, bit rdy);
        mdl_t n = x;
        bit mem = is_rd(x.ir) || is_wr(x.ir);
        bit tmo = (c_max[k] > 0) && (x.wt == c_max[k]);
        if (rst) begin
            n.ph = 0; n.ir = '0; n.wt = 0; n.terr = 0; n.cnt = 0;
            return n;
        end
        case (x.ph)
            0: if (run) begin n.ph = 1; n.wt = 0; end
            1: begin
                if (rdy) begin n.ir = ins; n.ph = 2; end
                else if (tmo) begin n.ph = 6; n.terr = 1; end
                else n.wt = x.wt + 1;
            end
            2: n.ph = 3;
            3: begin
                if (mem || !c_skip[k]) begin n.ph = 4; n.wt = 0; end
                else n.ph = 5;
            end
            4: begin
                if (!mem || rdy) n.ph = 5;
                else if (tmo) begin n.ph = 6; n.terr = 1; end
                else n.wt = x.wt + 1;
            end
            5: begin
                n.cnt = (x.cnt + 1) % (1 << c_cw[k]);
                n.ph = run ? 1 : 0;
                n.wt = 0;
            end
            default: n.ph = 6;
        endcase
        return n;
    endfunction

    function automatic obs_t expv(mdl_t x, bit rdy);
        obs_t e;
        e.st   = 3'(x.ph);
        e.ir   = x.ir;
        e.rd   = (x.ph == 1) || (x.ph == 4 && is_rd(x.ir));
        e.wr   = (x.ph == 4) && is_wr(x.ir);
        e.irl  = (x.ph == 1) && rdy;
        e.rfr  = (x.ph == 2);
        e.rfw  = (x.ph == 5) && rf_wr(x.ir);
        e.pcl  = (x.ph == 5);
        e.busy = (x.ph >= 1) && (x.ph <= 5);
        e.terr = x.terr;
        e.cnt  = 16'(x.cnt);
        return e;
    endfunction

    task automatic cmp(input string t, input obs_t a, input obs_t e);
        ck({t, ".STATE"}, 64'(a.st), 64'(e.st));
        ck({t, ".IR"}, 64'(a.ir), 64'(e.ir));
        ck({t, ".READ"}, 64'(a.rd), 64'(e.rd));
        ck({t, ".WRITE"}, 64'(a.wr), 64'(e.wr));
        ck({t, ".IR_LOAD"}, 64'(a.irl), 64'(e.irl));
        ck({t, ".RF_READ"}, 64'(a.rfr), 64'(e.rfr));
        ck({t, ".RF_WRITE"}, 64'(a.rfw), 64'(e.rfw));
        ck({t, ".PC_LOAD"}, 64'(a.pcl), 64'(e.pcl));
        ck({t, ".BUSY"}, 64'(a.busy), 64'(e.busy));
        ck({t, ".TIMEOUT_ERR"}, 64'(a.terr), 64'(e.terr));
        ck({t, ".INST_COUNT"}, 64'(a.cnt), 64'(e.cnt));
        ck({t, ".RDWR_EXCL"}, 64'(a.rd & a.wr), 64'd0);
    endtask

    always @(posedge CLK) begin
        m[0] <= nxt(m[0], 0, RST, RUN, INSTRUCTION, MEM_READY);
        m[1] <= nxt(m[1], 1, RST, RUN, INSTRUCTION, MEM_READY);
    end

    always @(negedge CLK) begin
        if (mon_en) begin
            cmp("m0", o0, expv(m[0], MEM_READY));
            cmp("m1", o1, expv(m[1], MEM_READY));
        end
    end

    task automatic cyc(input bit rst, input bit run,
                       input logic [31:0] ins, input bit rdy);
        @(posedge CLK);
        #1;
        RST = rst;
        RUN = run;
        INSTRUCTION = ins;
        MEM_READY = rdy;
        @(negedge CLK);
    endtask

    logic [5:0] ops[12] = '{6'h00, 6'h00, 6'h23, 6'h2b, 6'h1c, 6'h1b,
                            6'h08, 6'h1d, 6'h0c, 6'h0f, 6'h03, 6'h04};

    initial begin
        logic [31:0] ri;
        int pr;

        // Reset and a single add with zero-wait memory.
        cyc(1, 0, '0, 0);
        mon_en = 1'b1;
        ck("rst.STATE", 64'(st0), 64'd0);
        ck("rst.IR", 64'(ir0), 64'd0);
        ck("rst.BUSY", 64'(busy0), 64'd0);
        ck("rst.CNT", 64'(cnt0), 64'd0);
        ck("rst.TERR", 64'(terr0), 64'd0);
        cyc(0, 1, ADD, 1);
        ck("add.c0", 64'(st0), 64'd0);
        cyc(0, 1, ADD, 1);
        ck("add.c1", 64'(st0), 64'd1);
        ck("add.c1.READ", 64'(rd0), 64'd1);
        ck("add.c1.IRL", 64'(irl0), 64'd1);
        cyc(0, 1, ADD, 1);
        ck("add.c2", 64'(st0), 64'd2);
        ck("add.c2.RFR", 64'(rfr0), 64'd1);
        ck("add.c2.IR", 64'(ir0), 64'(ADD));
        cyc(0, 1, ADD, 1);
        ck("add.c3", 64'(st0), 64'd3);
        cyc(0, 1, ADD, 1);
        ck("add.c4", 64'(st0), 64'd5);
        ck("add.c4.RFW", 64'(rfw0), 64'd1);
        ck("add.c4.PCL", 64'(pcl0), 64'd1);
        ck("add1.c4", 64'(st1), 64'd4);
        ck("add1.c4.RW", 64'({rd1, wr1}), 64'd0);
        cyc(0, 1, ADD, 1);
        ck("add.c5", 64'(st0), 64'd1);
        ck("add.c5.CNT", 64'(cnt0), 64'd1);
        ck("add1.c5", 64'(st1), 64'd5);

        // lw with three wait cycles in MEM.
        cyc(1, 0, '0, 0);
        cyc(0, 1, LW, 1);
        cyc(0, 1, LW, 1);
        cyc(0, 1, LW, 1);
        cyc(0, 1, LW, 0);
        ck("lw.exe", 64'(st0), 64'd3);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, LW, i == 3);
            ck("lw.mem", 64'(st0), 64'd4);
            ck("lw.mem.READ", 64'(rd0), 64'd1);
            ck("lw1.mem.READ", 64'(rd1), 64'd1);
        end
        cyc(0, 1, LW, 1);
        ck("lw.wb", 64'(st0), 64'd5);
        ck("lw.wb.RFW", 64'(rfw0), 64'd1);
        ck("lw.wb.READ", 64'(rd0), 64'd0);

        // sw through MEM on the no-skip instance.
        cyc(1, 0, '0, 0);
        cyc(0, 1, SW, 1);
        cyc(0, 1, SW, 1);
        cyc(0, 1, SW, 1);
        cyc(0, 1, SW, 1);
        ck("sw1.exe.WR", 64'(wr1), 64'd0);
        cyc(0, 1, SW, 1);
        ck("sw1.mem", 64'(st1), 64'd4);
        ck("sw1.mem.WR", 64'({rd1, wr1}), 64'd1);
        cyc(0, 1, SW, 1);
        ck("sw1.wb", 64'(st1), 64'd5);
        ck("sw1.wb.RFW", 64'(rfw1), 64'd0);
        ck("sw1.wb.WR", 64'(wr1), 64'd0);

        // Fetch timeout: 16 waiting FETCH cycles, then HALT.
        cyc(1, 0, '0, 0);
        cyc(0, 1, ADD, 0);
        for (int i = 0; i < 16; i++) begin
            cyc(0, 1, ADD, 0);
            ck("tmo.fetch", 64'(st0), 64'd1);
        end
        cyc(0, 1, ADD, 0);
        ck("tmo.halt", 64'(st0), 64'd6);
        ck("tmo.TERR", 64'(terr0), 64'd1);
        ck("tmo.BUSY", 64'(busy0), 64'd0);
        ck("tmo1.nohalt", 64'(st1), 64'd1);
        cyc(0, 1, ADD, 1);
        ck("tmo.sticky", 64'({st0, terr0}), 64'({3'd6, 1'b1}));
        cyc(1, 0, '0, 0);
        cyc(0, 0, '0, 0);
        ck("tmo.rst", 64'({st0, terr0}), 64'd0);

        // RUN dropped during EXE.
        cyc(1, 0, '0, 0);
        cyc(0, 1, ADD, 1);
        cyc(0, 1, ADD, 1);
        cyc(0, 1, ADD, 1);
        cyc(0, 0, ADD, 1);
        ck("run.exe", 64'(st0), 64'd3);
        cyc(0, 0, ADD, 1);
        ck("run.wb", 64'(st0), 64'd5);
        cyc(0, 0, ADD, 1);
        ck("run.idle", 64'(st0), 64'd0);
        ck("run.idle.CNT", 64'(cnt0), 64'd1);
        cyc(0, 1, ADD, 1);
        cyc(0, 1, ADD, 1);
        ck("run.fetch", 64'(st0), 64'd1);
        for (int i = 0; i < 4; i++) cyc(0, 1, ADD, 1);
        ck("run.CNT", 64'(cnt0), 64'd2);

        // Reset in the middle of a write access.
        cyc(1, 0, '0, 0);
        cyc(0, 1, SW, 1);
        cyc(0, 1, SW, 1);
        cyc(0, 1, SW, 1);
        cyc(0, 1, SW, 0);
        cyc(0, 1, SW, 0);
        ck("rstmem.WR", 64'({st0, wr0}), 64'({3'd4, 1'b1}));
        cyc(1, 1, SW, 0);
        cyc(0, 0, '0, 0);
        ck("rstmem.after", 64'({st0, wr0, busy0}), 64'd0);
        ck("rstmem.IR", 64'(ir0), 64'd0);

        // Counter wrap on the 4-bit instance.
        cyc(1, 0, '0, 0);
        for (int i = 0; i <= 81; i++) begin
            cyc(0, 1, ADD, 1);
            if (i == 76) ck("wrap.15", 64'(cnt1), 64'd15);
            if (i == 81) begin
                ck("wrap.0", 64'(cnt1), 64'd0);
                ck("wrap.st", 64'(st1), 64'd1);
                ck("wrap.d0", 64'(cnt0), 64'd20);
            end
        end

        // Randomised traffic with phases of scarce MEM_READY.
        for (int n = 0; n < 3000; n++) begin
            pr = ((n / 250) % 3 == 1) ? 1 : 6;
            ri = $urandom;
            ri[31:26] = ops[$urandom_range(0, 11)];
            if ($urandom_range(0, 3) == 0) ri[5:0] = 6'h08;
            cyc($urandom_range(0, 149) == 0,
                $urandom_range(0, 9) != 0,
                ri,
                $urandom_range(0, 9) < pr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/proc_stage_sequencer.md
Name: proc_stage_sequencer

Overview:
- Parametrised multi-cycle stage sequencer for the processor.
- Steps each instruction through FETCH/DECODE/EXE/MEM/WB and latches the instruction register.
- Holds memory READ/WRITE requests until the memory acknowledges with MEM_READY, and can skip MEM for non-memory ops.
- Detects memory timeouts and supports run/stop. Sits between the memory interface and the datapath control decoder, which consumes STATE and IR.

Parameters:
- DATA_WIDTH, 32: instruction width, must be >= 32. Opcode is IR[DATA_WIDTH-1:DATA_WIDTH-6]; funct is IR[5:0].
- MEM_WAIT_MAX, 15: maximum wait cycles per memory access. 0 disables the timeout.
- SKIP_MEM, 1: 1 means non-memory ops go EXE->WB; 0 means every op passes through MEM.
- CNT_WIDTH, 16: width of the retired-instruction counter.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- RUN  in  1  enable sequencing.
- INSTRUCTION  in  DATA_WIDTH  memory read data during FETCH.
- MEM_READY  in  1  memory acknowledge for the current READ/WRITE.
- STATE  out  3  current state encoding.
- IR  out  DATA_WIDTH  latched instruction.
- READ  out  1  memory read request.
- WRITE  out  1  memory write request.
- IR_LOAD  out  1  instruction capture strobe.
- RF_READ  out  1  register file read enable.
- RF_WRITE  out  1  register file write enable.
- PC_LOAD  out  1  PC update strobe.
- BUSY  out  1  high in every state except IDLE and HALT.
- TIMEOUT_ERR  out  1  sticky memory timeout flag.
- INST_COUNT  out  CNT_WIDTH  retired-instruction count.

Behaviour:
- Reset (RST high at an edge):
  - STATE=IDLE, IR=0, INST_COUNT=0, TIMEOUT_ERR=0, wait counter=0.
  - All strobes are 0 and BUSY=0.
  - RST overrides everything, including mid-access and HALT.
- States: IDLE=0, FETCH=1, DECODE=2, EXE=3, MEM=4, WB=5, HALT=6. Encoding 7 is illegal and goes to HALT.
- IDLE: go to FETCH when RUN=1, otherwise stay.
- FETCH:
  - READ=1.
  - IR_LOAD = MEM_READY (combinational).
  - On an edge with MEM_READY=1: IR<=INSTRUCTION and next state is DECODE.
  - Otherwise stay in FETCH and wait.
- DECODE: RF_READ=1 for one cycle, then EXE.
- EXE: no strobes, one cycle.
  - Next state is MEM if the op is a memory op, or if SKIP_MEM=0.
  - Otherwise next state is WB.
- Memory ops:
  - Reads: lw 0x23, pop 0x1c.
  - Writes: sw 0x2b, push 0x1b.
- MEM:
  - READ=1 for reads; WRITE=1 for writes.
  - Wait for MEM_READY as in FETCH, then go to WB.
  - A non-memory op (SKIP_MEM=0) spends exactly one MEM cycle with READ=WRITE=0 and ignores MEM_READY.
- WB:
  - PC_LOAD=1.
  - RF_WRITE=1 for: R-type except jr (funct 0x08); opcodes 0x08, 0x1d, 0x0c, 0x0d, 0x0f, 0x0a, 0x23, 0x03, 0x1c.
  - INST_COUNT increments (wraps modulo 2^CNT_WIDTH).
  - Next state is FETCH if RUN=1, otherwise IDLE.
  - RUN is sampled only in IDLE and WB; an instruction in flight always completes.
- Wait counter:
  - Cleared on entry to FETCH/MEM.
  - Increments on each cycle in FETCH/MEM with MEM_READY=0.
  - If MEM_WAIT_MAX>0 and the counter equals MEM_WAIT_MAX while MEM_READY=0: next state is HALT and TIMEOUT_ERR<=1. A MEM_READY arriving on that same cycle is accepted instead.
  - READ and WRITE are never both 1.
- HALT: all strobes 0, BUSY=0. Exits only via RST.
- Latency with zero-wait memory and SKIP_MEM=1: ALU op 4 cycles, memory op 5 cycles. With SKIP_MEM=0: 5 cycles for every op.
- READ/WRITE stay stable from entry to the state until the MEM_READY edge.

Decomposition:
- Shared package proc_seq_pkg holds:
  - state encodings;
  - opcode/funct constants (LW, SW, PUSH, POP, JR, JAL, ...).
- One combinational sub-module proc_op_classifier takes the IR opcode/funct and returns is_mem_read, is_mem_write and is_rf_write. It is reused by the datapath control decoder.

Test Plan:
- Reset, RUN=1, zero-wait memory, INSTRUCTION=0x00221820 (add) -> STATE 1,2,3,5,1. RF_READ in cycle 2, RF_WRITE and PC_LOAD in cycle 4, INST_COUNT=1.
- lw 0x8C220004 with MEM_READY low for 3 cycles in MEM -> READ held 4 cycles in MEM, then WB with RF_WRITE=1. Total 8 cycles.
- sw 0xAC220004 with SKIP_MEM=0 -> WRITE=1 in MEM only, RF_WRITE=0 in WB. Repeat with add: MEM is 1 cycle with READ=WRITE=0.
- MEM_WAIT_MAX=15, MEM_READY never high in FETCH -> HALT after 16 FETCH cycles, TIMEOUT_ERR=1 sticky. RST then gives IDLE and TIMEOUT_ERR=0.
- RUN dropped during EXE -> instruction completes WB then goes to IDLE. RUN=1 resumes FETCH; INST_COUNT is continuous.
- RST asserted mid-MEM with WRITE=1 -> next cycle STATE=IDLE, WRITE=0, IR=0. CNT_WIDTH=4: 16 instructions wrap INST_COUNT to 0.
